// File: rtl/exu_div_ctrl.sv
// ============================================================================
// exu_div_ctrl : two-port round-robin front end and sequencer for an iterative divider
// Rev 1.0
// ============================================================================
`default_nettype none

`ifndef REG_DATA_WIDTH
`define REG_DATA_WIDTH 32
`endif

module exu_div_ctrl #(
  parameter int TAG_W = 5,
  parameter int DW    = `REG_DATA_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,

  input  logic             req0_valid_i,
  output logic             req0_ready_o,
  input  logic [DW-1:0]    req0_dividend_i,
  input  logic [DW-1:0]    req0_divisor_i,
  input  logic [3:0]       req0_op_i,
  input  logic [TAG_W-1:0] req0_tag_i,

  input  logic             req1_valid_i,
  output logic             req1_ready_o,
  input  logic [DW-1:0]    req1_dividend_i,
  input  logic [DW-1:0]    req1_divisor_i,
  input  logic [3:0]       req1_op_i,
  input  logic [TAG_W-1:0] req1_tag_i,

  input  logic             flush_i,

  output logic [DW-1:0]    div_dividend_o,
  output logic [DW-1:0]    div_divisor_o,
  output logic [3:0]       div_op_o,
  output logic             div_start_o,
  input  logic [DW-1:0]    div_result_i,
  input  logic             div_busy_i,
  input  logic             div_valid_i,

  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [DW-1:0]    out_result_o,
  output logic [TAG_W-1:0] out_tag_o,
  output logic             out_port_o,

  output logic             busy_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  localparam logic [DW-1:0] c_all_ones = {DW{1'b1}};
  localparam logic [DW-1:0] c_int_min  = {1'b1, {(DW-1){1'b0}}};

  state_e           state_q, state_d;
  logic             prio_q, prio_d;
  logic [DW-1:0]    dividend_q, dividend_d;
  logic [DW-1:0]    divisor_q, divisor_d;
  logic [DW-1:0]    result_q, result_d;
  logic [3:0]       op_q, op_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             port_q, port_d;

  logic             w_idle;
  logic             w_grant;
  logic             w_accept;
  logic [DW-1:0]    w_sel_dividend;
  logic [DW-1:0]    w_sel_divisor;
  logic [3:0]       w_sel_op;
  logic [TAG_W-1:0] w_sel_tag;
  logic             w_is_div;
  logic             w_is_signed;
  logic             w_div_zero;
  logic             w_overflow;
  logic             w_bypass;
  logic [DW-1:0]    w_bypass_result;

  assign w_idle = (state_q == S_IDLE);

  // Contention goes to the pointer; a lone requester always wins.
  always_comb begin
    w_grant = 1'b0;
    if (req0_valid_i && req1_valid_i) begin
      w_grant = prio_q;
    end else if (req1_valid_i) begin
      w_grant = 1'b1;
    end
  end

  assign req0_ready_o = rst_n & w_idle & ~flush_i & req0_valid_i & ~w_grant;
  assign req1_ready_o = rst_n & w_idle & ~flush_i & req1_valid_i &  w_grant;
  assign w_accept     = req0_ready_o | req1_ready_o;

  assign w_sel_dividend = w_grant ? req1_dividend_i : req0_dividend_i;
  assign w_sel_divisor  = w_grant ? req1_divisor_i  : req0_divisor_i;
  assign w_sel_op       = w_grant ? req1_op_i       : req0_op_i;
  assign w_sel_tag      = w_grant ? req1_tag_i      : req0_tag_i;

  // op one-hot: [0]=DIV [1]=DIVU [2]=REM [3]=REMU
  assign w_is_div    = w_sel_op[0] | w_sel_op[1];
  assign w_is_signed = w_sel_op[0] | w_sel_op[2];
  assign w_div_zero  = (w_sel_divisor == '0);
  assign w_overflow  = w_is_signed && (w_sel_dividend == c_int_min) && (w_sel_divisor == c_all_ones);
  assign w_bypass    = w_div_zero | w_overflow;

  always_comb begin
    w_bypass_result = '0;
    if (w_div_zero) begin
      w_bypass_result = w_is_div ? c_all_ones : w_sel_dividend;
    end else if (w_overflow) begin
      w_bypass_result = w_is_div ? c_int_min : '0;
    end
  end

  assign div_start_o = rst_n & (state_q == S_ISSUE) & ~div_busy_i;

  always_comb begin
    state_d    = state_q;
    prio_d     = prio_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    op_d       = op_q;
    tag_d      = tag_q;
    port_d     = port_q;
    result_d   = result_q;
    case (state_q)
      S_IDLE: begin
        if (w_accept) begin
          prio_d     = ~w_grant;
          dividend_d = w_sel_dividend;
          divisor_d  = w_sel_divisor;
          op_d       = w_sel_op;
          tag_d      = w_sel_tag;
          port_d     = w_grant;
          if (w_bypass) begin
            result_d = w_bypass_result;
            state_d  = S_DONE;
          end else begin
            state_d  = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        // A start that coincides with a flush still launches the divider, so drain it.
        if (flush_i) begin
          state_d = div_start_o ? S_DRAIN : S_IDLE;
        end else if (div_start_o) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (flush_i) begin
          state_d = div_valid_i ? S_IDLE : S_DRAIN;
        end else if (div_valid_i) begin
          result_d = div_result_i;
          state_d  = S_DONE;
        end
      end
      S_DRAIN: begin
        if (div_valid_i) begin
          state_d = S_IDLE;
        end
      end
      S_DONE: begin
        if (flush_i || out_ready_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      prio_q     <= 1'b0;
      dividend_q <= '0;
      divisor_q  <= '0;
      op_q       <= '0;
      tag_q      <= '0;
      port_q     <= 1'b0;
      result_q   <= '0;
    end else begin
      state_q    <= state_d;
      prio_q     <= prio_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      op_q       <= op_d;
      tag_q      <= tag_d;
      port_q     <= port_d;
      result_q   <= result_d;
    end
  end

  assign div_dividend_o = dividend_q;
  assign div_divisor_o  = divisor_q;
  assign div_op_o       = op_q;
  assign out_valid_o    = (state_q == S_DONE);
  assign out_result_o   = result_q;
  assign out_tag_o      = tag_q;
  assign out_port_o     = port_q;
  assign busy_o         = ~w_idle;

endmodule

`default_nettype wire

// File: tb/tb_exu_div_ctrl.sv
// ============================================================================
// tb_exu_div_ctrl : directed self-checking bench for exu_div_ctrl
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_exu_div_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid_i, req1_valid_i;
  logic        req0_ready_o, req1_ready_o;
  logic [31:0] req0_dividend_i, req0_divisor_i, req1_dividend_i, req1_divisor_i;
  logic [3:0]  req0_op_i, req1_op_i;
  logic [4:0]  req0_tag_i, req1_tag_i;
  logic        flush_i;
  logic [31:0] div_dividend_o, div_divisor_o;
  logic [3:0]  div_op_o;
  logic        div_start_o;
  logic [31:0] div_result_i;
  logic        div_busy_i, div_valid_i;
  logic        out_valid_o, out_ready_i;
  logic [31:0] out_result_o;
  logic [4:0]  out_tag_o;
  logic        out_port_o;
  logic        busy_o;

  int n_assert = 0;
  int n_fail   = 0;

  localparam logic [3:0] OP_DIV  = 4'b0001;
  localparam logic [3:0] OP_DIVU = 4'b0010;
  localparam logic [3:0] OP_REM  = 4'b0100;
  localparam logic [3:0] OP_REMU = 4'b1000;

  exu_div_ctrl #(.TAG_W(5), .DW(32)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req0_valid_i    (req0_valid_i),
    .req0_ready_o    (req0_ready_o),
    .req0_dividend_i (req0_dividend_i),
    .req0_divisor_i  (req0_divisor_i),
    .req0_op_i       (req0_op_i),
    .req0_tag_i      (req0_tag_i),
    .req1_valid_i    (req1_valid_i),
    .req1_ready_o    (req1_ready_o),
    .req1_dividend_i (req1_dividend_i),
    .req1_divisor_i  (req1_divisor_i),
    .req1_op_i       (req1_op_i),
    .req1_tag_i      (req1_tag_i),
    .flush_i         (flush_i),
    .div_dividend_o  (div_dividend_o),
    .div_divisor_o   (div_divisor_o),
    .div_op_o        (div_op_o),
    .div_start_o     (div_start_o),
    .div_result_i    (div_result_i),
    .div_busy_i      (div_busy_i),
    .div_valid_i     (div_valid_i),
    .out_valid_o     (out_valid_o),
    .out_ready_i     (out_ready_i),
    .out_result_o    (out_result_o),
    .out_tag_o       (out_tag_o),
    .out_port_o      (out_port_o),
    .busy_o          (busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic expd);
    n_assert++;
    assert (obs === expd) else begin
      n_fail++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, expd);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] expd);
    n_assert++;
    assert (obs === expd) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expd);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input logic v, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] tag);
    req0_valid_i = v; req0_op_i = op; req0_dividend_i = a; req0_divisor_i = b; req0_tag_i = tag;
  endtask

  task automatic drive1(input logic v, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] tag);
    req1_valid_i = v; req1_op_i = op; req1_dividend_i = a; req1_divisor_i = b; req1_tag_i = tag;
  endtask

  // Full divider-path transaction; the bench plays the divider and returns res after lat busy cycles.
  task automatic op_div(input logic exp_port, input logic [3:0] exp_op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] tag, input logic [31:0] res,
                        input int lat);
    #1;
    chk1("accept_ready0", req0_ready_o, ~exp_port);
    chk1("accept_ready1", req1_ready_o, exp_port);
    step();
    chk1("issue_start", div_start_o, 1'b1);
    chk32("issue_dividend", div_dividend_o, a);
    chk32("issue_divisor", div_divisor_o, b);
    chk32("issue_op", {28'd0, div_op_o}, {28'd0, exp_op});
    step();
    chk1("wait_start_low", div_start_o, 1'b0);
    div_busy_i = 1'b1;
    for (int i = 0; i < lat; i++) begin
      step();
      chk1("wait_no_out_valid", out_valid_o, 1'b0);
    end
    div_valid_i  = 1'b1;
    div_result_i = res;
    step();
    div_valid_i  = 1'b0;
    div_busy_i   = 1'b0;
    div_result_i = 32'd0;
    chk1("done_valid", out_valid_o, 1'b1);
    chk32("done_result", out_result_o, res);
    chk32("done_tag", {27'd0, out_tag_o}, {27'd0, tag});
    chk1("done_port", out_port_o, exp_port);
    out_ready_i = 1'b1;
    step();
    out_ready_i = 1'b0;
    chk1("handshake_clear", out_valid_o, 1'b0);
  endtask

  // Bypass transaction: result one cycle after accept, divider never started.
  task automatic op_byp(input logic exp_port, input logic [31:0] res, input logic [4:0] tag);
    #1;
    chk1("byp_ready0", req0_ready_o, ~exp_port);
    chk1("byp_ready1", req1_ready_o, exp_port);
    step();
    chk1("byp_no_start", div_start_o, 1'b0);
    chk1("byp_valid", out_valid_o, 1'b1);
    chk32("byp_result", out_result_o, res);
    chk32("byp_tag", {27'd0, out_tag_o}, {27'd0, tag});
    chk1("byp_port", out_port_o, exp_port);
    out_ready_i = 1'b1;
    step();
    out_ready_i = 1'b0;
    chk1("byp_clear", out_valid_o, 1'b0);
    chk1("byp_no_start_after", div_start_o, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    flush_i = 1'b0; out_ready_i = 1'b0;
    div_result_i = 32'd0; div_busy_i = 1'b0; div_valid_i = 1'b0;
    drive0(1'b1, OP_DIV, 32'd1, 32'd1, 5'd1);
    drive1(1'b0, OP_DIV, 32'd0, 32'd0, 5'd0);

    // Reset state, with a requester valid to show ready stays low
    repeat (2) step();
    chk1("rst_ready0", req0_ready_o, 1'b0);
    chk1("rst_start", div_start_o, 1'b0);
    chk1("rst_out_valid", out_valid_o, 1'b0);
    chk1("rst_busy", busy_o, 1'b0);
    chk32("rst_result", out_result_o, 32'd0);
    chk32("rst_div_dividend", div_dividend_o, 32'd0);
    req0_valid_i = 1'b0;
    rst_n = 1'b1;
    step();

    // DIV 100/7 and REM 100/7 on port 0
    drive0(1'b1, OP_DIV, 32'd100, 32'd7, 5'd3);
    op_div(1'b0, OP_DIV, 32'd100, 32'd7, 5'd3, 32'd14, 3);
    req0_valid_i = 1'b0;
    drive0(1'b1, OP_REM, 32'd100, 32'd7, 5'd3);
    op_div(1'b0, OP_REM, 32'd100, 32'd7, 5'd3, 32'd2, 2);
    req0_valid_i = 1'b0;

    // DIVU 5/0 from port 1 (also leaves the pointer at port 0)
    drive1(1'b1, OP_DIVU, 32'd5, 32'd0, 5'd4);
    op_byp(1'b1, 32'hFFFF_FFFF, 5'd4);
    req1_valid_i = 1'b0;

    // Both requesters held: grants alternate 0,1,0,1
    drive0(1'b1, OP_DIVU, 32'd1000, 32'd10, 5'd7);
    drive1(1'b1, OP_DIV, 32'hFFFF_FFEC, 32'd3, 5'd9);
    op_div(1'b0, OP_DIVU, 32'd1000, 32'd10, 5'd7, 32'd100, 1);
    op_div(1'b1, OP_DIV, 32'hFFFF_FFEC, 32'd3, 5'd9, 32'hFFFF_FFFA, 2);
    op_div(1'b0, OP_DIVU, 32'd1000, 32'd10, 5'd7, 32'd100, 1);
    op_div(1'b1, OP_DIV, 32'hFFFF_FFEC, 32'd3, 5'd9, 32'hFFFF_FFFA, 2);
    req0_valid_i = 1'b0;
    req1_valid_i = 1'b0;

    // Remaining bypass corners
    drive0(1'b1, OP_REMU, 32'd5, 32'd0, 5'd5);
    op_byp(1'b0, 32'd5, 5'd5);
    req0_valid_i = 1'b0;
    drive0(1'b1, OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6);
    op_byp(1'b0, 32'h8000_0000, 5'd6);
    req0_valid_i = 1'b0;
    drive0(1'b1, OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6);
    op_byp(1'b0, 32'd0, 5'd6);
    req0_valid_i = 1'b0;
    // Unsigned with the same operands is an ordinary divide
    drive0(1'b1, OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6);
    op_div(1'b0, OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6, 32'd0, 1);
    req0_valid_i = 1'b0;

    // Flush during WAIT -> DRAIN until divider reports, no output
    drive0(1'b1, OP_DIV, 32'd50, 32'd5, 5'd1);
    #1;
    chk1("fw_accept", req0_ready_o, 1'b1);
    step();
    req0_valid_i = 1'b0;
    chk1("fw_start", div_start_o, 1'b1);
    step();
    div_busy_i = 1'b1;
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    chk1("fw_drain_busy", busy_o, 1'b1);
    chk1("fw_drain_no_valid", out_valid_o, 1'b0);
    drive1(1'b1, OP_DIVU, 32'd77, 32'd7, 5'd2);
    #1;
    chk1("fw_drain_ready1_a", req1_ready_o, 1'b0);
    step();
    chk1("fw_drain_ready1_b", req1_ready_o, 1'b0);
    div_valid_i  = 1'b1;
    div_result_i = 32'd10;
    #1;
    chk1("fw_drain_ready1_c", req1_ready_o, 1'b0);
    step();
    div_valid_i  = 1'b0;
    div_busy_i   = 1'b0;
    div_result_i = 32'd0;
    chk1("fw_discard_valid", out_valid_o, 1'b0);
    chk1("fw_idle", busy_o, 1'b0);
    op_div(1'b1, OP_DIVU, 32'd77, 32'd7, 5'd2, 32'd11, 1);
    req1_valid_i = 1'b0;

    // Flush in ISSUE while divider busy -> IDLE with no start pulse
    div_busy_i = 1'b1;
    drive0(1'b1, OP_DIV, 32'd9, 32'd3, 5'd8);
    #1;
    chk1("fi_accept", req0_ready_o, 1'b1);
    step();
    req0_valid_i = 1'b0;
    chk1("fi_hold_start", div_start_o, 1'b0);
    chk1("fi_busy", busy_o, 1'b1);
    flush_i = 1'b1;
    #1;
    chk1("fi_flush_start", div_start_o, 1'b0);
    step();
    flush_i = 1'b0;
    div_busy_i = 1'b0;
    chk1("fi_idle", busy_o, 1'b0);
    chk1("fi_no_start", div_start_o, 1'b0);
    chk1("fi_no_valid", out_valid_o, 1'b0);

    // DONE held 10 cycles with consumer stalled, then flushed
    drive0(1'b1, OP_DIVU, 32'd5, 32'd0, 5'd2);
    #1;
    chk1("st_accept", req0_ready_o, 1'b1);
    step();
    drive1(1'b1, OP_DIV, 32'd1, 32'd1, 5'd1);
    for (int i = 0; i < 10; i++) begin
      chk1("st_valid", out_valid_o, 1'b1);
      chk32("st_result", out_result_o, 32'hFFFF_FFFF);
      chk32("st_tag", {27'd0, out_tag_o}, 32'd2);
      chk1("st_port", out_port_o, 1'b0);
      chk1("st_ready0", req0_ready_o, 1'b0);
      chk1("st_ready1", req1_ready_o, 1'b0);
      step();
    end
    flush_i = 1'b1;
    req0_valid_i = 1'b0;
    req1_valid_i = 1'b0;
    step();
    flush_i = 1'b0;
    chk1("df_cleared", out_valid_o, 1'b0);
    chk1("df_idle", busy_o, 1'b0);

    // Reset asserted in WAIT abandons the op
    drive0(1'b1, OP_DIV, 32'd9, 32'd3, 5'd10);
    step();
    req0_valid_i = 1'b0;
    step();
    div_busy_i = 1'b1;
    chk1("rw_in_wait", busy_o, 1'b1);
    rst_n = 1'b0;
    req0_valid_i = 1'b1;
    step();
    chk1("rw_ready0", req0_ready_o, 1'b0);
    chk1("rw_start", div_start_o, 1'b0);
    chk1("rw_busy", busy_o, 1'b0);
    chk1("rw_out_valid", out_valid_o, 1'b0);
    chk32("rw_result", out_result_o, 32'd0);
    chk32("rw_tag", {27'd0, out_tag_o}, 32'd0);
    chk32("rw_div_dividend", div_dividend_o, 32'd0);
    chk32("rw_div_divisor", div_divisor_o, 32'd0);
    chk32("rw_div_op", {28'd0, div_op_o}, 32'd0);
    rst_n = 1'b1;
    req0_valid_i = 1'b0;
    div_valid_i = 1'b1;
    div_result_i = 32'd3;
    step();
    div_valid_i = 1'b0;
    div_busy_i = 1'b0;
    chk1("rw_post_no_valid", out_valid_o, 1'b0);
    chk1("rw_post_idle", busy_o, 1'b0);
    step();
    chk1("rw_post_no_valid2", out_valid_o, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
